// File: rtl/freq_reg_pkg.sv
// Shared settings of the frequency-regulation loop: divider widths, limits and
// the handshake state encoding.
package freq_reg_pkg;
  localparam int WIDTH     = 8;
  localparam int MIN_DIV   = 2;
  localparam int RESET_DIV = 100;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } ctl_state_e;
endpackage

// File: rtl/div_period_counter.sv
// Period counter for the divider: counts 0..N-1 while enabled and produces the
// registered divided clock and end-of-period tick.
module div_period_counter #(
  parameter int WIDTH = 8
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             tick_o,
  output logic             div_clk_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   half;
  logic             last;
  logic             tick_q, div_clk_q;

  // Compares run one bit wider so N=255 needs no special case.
  always_comb begin
    half  = ({1'b0, n_i} + 1'b1) >> 1;
    last  = ({1'b0, cnt_q} + 1'b1) == {1'b0, n_i};
    cnt_d = cnt_q + 1'b1;
    if (!en_i || last) cnt_d = '0;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      div_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= en_i && last;
      div_clk_q <= en_i && ({1'b0, cnt_q} < half);
    end
  end

  assign tick_o    = tick_q;
  assign div_clk_o = div_clk_q;
endmodule

// File: rtl/freq_divider_actuator.sv
// Glitch-free programmable divider: new divisors are held in a shadow register
// and switched in only at a period boundary (or at once while disabled).
module freq_divider_actuator #(
  parameter int WIDTH     = freq_reg_pkg::WIDTH,
  parameter int MIN_DIV   = freq_reg_pkg::MIN_DIV,
  parameter int RESET_DIV = freq_reg_pkg::RESET_DIV
) (
  input  logic             clk_frequency,
  input  logic             rst_frequency,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             load,
  output logic             load_ack,
  output logic             busy,
  output logic [WIDTH-1:0] active_div,
  output logic             div_clk,
  output logic             tick
);
  import freq_reg_pkg::*;

  ctl_state_e       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] div_clamped;
  logic             ack_q, ack_d;
  logic             apply;
  logic             tick_w;

  assign div_clamped = (div_in < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_in;

  // The counter's tick is registered, so the swap lands exactly as the new
  // period's second cycle is evaluated; its first cycle is N-independent.
  assign apply = (state_q == ST_PENDING) && (tick_w || !en);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ack_d    = 1'b0;
    if (apply) begin
      active_d = shadow_q;
      ack_d    = 1'b1;
      state_d  = ST_IDLE;
    end
    if (load) begin
      shadow_d = div_clamped;
      state_d  = ST_PENDING;
    end
  end

  always_ff @(posedge clk_frequency or negedge rst_frequency) begin
    if (!rst_frequency) begin
      state_q  <= ST_IDLE;
      shadow_q <= WIDTH'(RESET_DIV);
      active_q <= WIDTH'(RESET_DIV);
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ack_q    <= ack_d;
    end
  end

  div_period_counter #(.WIDTH(WIDTH)) u_cnt (
    .gclk      (clk_frequency),
    .grst_n    (rst_frequency),
    .en_i      (en),
    .n_i       (active_q),
    .tick_o    (tick_w),
    .div_clk_o (div_clk)
  );

  assign tick       = tick_w;
  assign load_ack   = ack_q;
  assign busy       = (state_q == ST_PENDING);
  assign active_div = active_q;
endmodule

// File: doc/freq_divider_actuator.md
# freq_divider_actuator

Programmable clock divider that sits at the output end of the frequency-regulation loop. It takes the 8-bit division setting produced by `frequency_requlator` (its `adjusteddiv`) through a load/acknowledge handshake and generates the divided clock plus a one-cycle period tick. A new setting takes effect only at a period boundary, so the output never glitches or produces a runt period.

## Interface
Parameters:
- `WIDTH`, 8: width of the division setting.
- `MIN_DIV`, 2: smallest legal divisor. Smaller requests are clamped up to this value.
- `RESET_DIV`, 100: divisor in force after reset.

Ports:
- `clk_frequency`  in  1  system clock. The only clock in the block.
- `rst_frequency`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable.
- `div_in`  in  WIDTH  requested divisor N.
- `load`  in  1  request strobe. `div_in` is captured in any cycle where `load`=1.
- `load_ack`  out  1  one-cycle pulse when a captured divisor becomes active.
- `busy`  out  1  a captured divisor is waiting for a period boundary.
- `active_div`  out  WIDTH  divisor currently in force.
- `div_clk`  out  1  divided clock (registered).
- `tick`  out  1  one-cycle pulse in the last cycle of each output period.

## Operation
- Internal registers:
  - `cnt` counts 0..N-1, where N = `active_div`.
  - `shadow` holds the requested divisor (WIDTH bits).
  - `pending` flag, which drives `busy`.
- Clamp rule: a captured value is `div_in`, or `MIN_DIV` if `div_in` < `MIN_DIV` (so 0 and 1 become 2). No upper clamp; 255 is legal.
- `div_clk` is high when `cnt` < (N+1)>>1, otherwise low.
  - N=2: high 1 cycle, low 1 cycle.
  - N=3: high 2 cycles, low 1 cycle.
  - N=100: high 50 cycles, low 50 cycles.
- `tick` is 1 when `en`=1 and `cnt` = N-1.
- Period boundary = a cycle with `tick`=1. Next cycle: `cnt` goes to 0.
  - If `pending`=1 at the boundary: `active_div` takes `shadow`, `pending` clears, `load_ack` pulses.
- `load` with `pending`=0: `shadow` takes the clamped `div_in`, `pending` sets.
- `load` with `pending`=1: `shadow` is overwritten (last writer wins). Only one `load_ack` is produced, for the value that gets applied.
- `load` in the same cycle as a boundary:
  - With `pending`=0: the new value is not applied at this boundary. It is captured and applied at the next boundary.
  - With `pending`=1: the old `shadow` is applied and acknowledged, the new value is captured, and `pending` stays 1.
- `en`=0: `cnt` is held at 0, `div_clk`=0, `tick`=0.
  - A pending or new load is applied in the cycle after capture (no boundary is needed), with `load_ack` pulsing.
  - The period restarts at `cnt`=0 when `en` returns to 1.
- Control states: IDLE (`pending`=0) and PENDING (`pending`=1).
  - IDLE → PENDING on `load`.
  - PENDING → IDLE on a boundary without a coincident `load`, or on apply while disabled.
  - PENDING → PENDING on a boundary with a coincident `load`.

## Timing
- Reset values: `cnt`=0, `active_div`=`RESET_DIV`, `shadow`=`RESET_DIV`, `busy`=0, `load_ack`=0, `div_clk`=0, `tick`=0.
- All outputs are registered. Reset is asynchronous and clears the block mid-period; any pending load is discarded.
- Load latency: `load` at cycle t gives `busy`=1 at t+1.
- Apply latency: a boundary at cycle b gives, at b+1, `active_div` updated, `cnt`=0, `load_ack`=1 for that one cycle, and `busy`=0.
- The first period after an update has exactly the new length N.
- Worst-case delay from `load` to `load_ack` is N_old+1 cycles.

## Structure
- Shared package `freq_reg_pkg` holds `WIDTH`, `MIN_DIV` and `RESET_DIV`. The regulator and the bench use the same package.
- Natural sub-module: `div_period_counter`, containing `cnt`, `tick` and `div_clk` generation, with N as input. The top level holds `shadow`, `pending` and the handshake.

## Test plan
- Reset, then `en`=1 with no load → `active_div`=100; `div_clk` high 50 cycles, low 50; `tick` every 100 cycles.
- Load 4 at mid-period, running N=100 → `busy` high until the boundary; at boundary+1 `load_ack`=1 and `active_div`=4; next periods are 4 cycles (2 high, 2 low).
- Load 0, then load 1 → each is clamped; `active_div`=2 after the boundary; `div_clk` toggles every cycle.
- Loads 7 then 9 while `busy`=1 → a single `load_ack`; `active_div`=9; odd N gives 5 cycles high, 4 low.
- Load coincident with `tick`, `pending`=0, value 5 → not applied at this boundary; applied one period later.
- `en`=0 and load 10 → `load_ack` 2 cycles after `load`, `div_clk`=0. Then reset asserted mid-period with a load pending → all outputs at reset values; `active_div`=100.
